// File: rtl/sys_array_loader.sv
// Upstream loader for the systolic-array fetcher: assembles W then B from one element stream,
// then restarts the fetcher (reset pulse, start pulse) and waits for its ready with a watchdog.
module sys_array_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int ARRAY_W_W      = 2,
    parameter int ARRAY_W_L      = 5,
    parameter int ARRAY_A_W      = 5,
    parameter int ARRAY_A_L      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [DATA_WIDTH-1:0]                         s_data,
    input  logic                                          s_last,
    output logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]     input_data_w,
    output logic [ARRAY_A_W*ARRAY_A_L*DATA_WIDTH-1:0]     input_data_b,
    output logic                                          core_reset_n,
    output logic                                          start_comp,
    input  logic                                          comp_ready,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err_len,
    output logic                                          err_timeout,
    output logic [15:0]                                   job_count
);

    localparam int NW = ARRAY_W_W * ARRAY_W_L;
    localparam int NB = ARRAY_A_W * ARRAY_A_L;
    localparam int NT = NW + NB;
    localparam int IW = (NT > 1) ? $clog2(NT) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_PULSE_RST,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    logic [TW-1:0]           wdog_q;
    logic [TW-1:0]           wdog_d;
    logic [DATA_WIDTH-1:0]   w_q [NW];
    logic [DATA_WIDTH-1:0]   b_q [NB];
    logic                    s_ready_q;
    logic                    core_reset_n_q;
    logic                    start_comp_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_len_q;
    logic                    err_timeout_q;
    logic [15:0]             job_count_q;
    logic                    accept;

    assign accept = s_valid && s_ready_q;
    assign idx_d  = idx_q + IW'(1);
    assign wdog_d = wdog_q + TW'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_LOAD;
            idx_q          <= '0;
            wdog_q         <= '0;
            s_ready_q      <= 1'b0;
            core_reset_n_q <= 1'b1;
            start_comp_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_len_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            job_count_q    <= '0;
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
            for (int k = 0; k < NB; k++) b_q[k] <= '0;
        end else begin
            core_reset_n_q <= 1'b1;
            start_comp_q   <= 1'b0;
            done_q         <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        // Element position in the job selects W or B, both stored row-major.
                        for (int k = 0; k < NW; k++)
                            if (idx_q == IW'(k)) w_q[k] <= s_data;
                        for (int k = 0; k < NB; k++)
                            if (idx_q == IW'(NW + k)) b_q[k] <= s_data;
                        if (idx_q == '0) begin
                            err_len_q     <= 1'b0;
                            err_timeout_q <= 1'b0;
                        end
                        if (idx_q == IW'(NT - 1)) begin
                            state_q        <= S_PULSE_RST;
                            s_ready_q      <= 1'b0;
                            core_reset_n_q <= 1'b0;
                            busy_q         <= 1'b1;
                            idx_q          <= '0;
                            if (!s_last) err_len_q <= 1'b1;
                        end else if (s_last) begin
                            err_len_q <= 1'b1;
                            busy_q    <= 1'b0;
                            idx_q     <= '0;
                        end else begin
                            busy_q <= 1'b1;
                            idx_q  <= idx_d;
                        end
                    end else begin
                        s_ready_q <= 1'b1;
                    end
                end
                S_PULSE_RST: begin
                    state_q      <= S_START;
                    start_comp_q <= 1'b1;
                end
                S_START: begin
                    state_q <= S_WAIT;
                    wdog_q  <= '0;
                end
                S_WAIT: begin
                    // The count about to be reached is compared, so the abort lands TIMEOUT_CYCLES after start.
                    if (comp_ready) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        job_count_q <= job_count_q + 16'd1;
                        busy_q      <= 1'b0;
                    end else if (wdog_q == TW'(TIMEOUT_CYCLES - 2)) begin
                        state_q       <= S_LOAD;
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                        s_ready_q     <= 1'b1;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                S_DONE: begin
                    state_q   <= S_LOAD;
                    s_ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= S_LOAD;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Element [0][0] lands in the most significant slot of each packed bus.
    for (genvar k = 0; k < NW; k++) begin : g_pack_w
        assign input_data_w[(NW-1-k)*DATA_WIDTH +: DATA_WIDTH] = w_q[k];
    end
    for (genvar k = 0; k < NB; k++) begin : g_pack_b
        assign input_data_b[(NB-1-k)*DATA_WIDTH +: DATA_WIDTH] = b_q[k];
    end

    assign s_ready      = s_ready_q;
    assign core_reset_n = core_reset_n_q;
    assign start_comp   = start_comp_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_timeout_q;
    assign job_count    = job_count_q;

endmodule

// File: tb/tb_sys_array_loader.sv
// Directed-sequence bench for sys_array_loader with random data/gaps and a stream-level reference model.
module tb_sys_array_loader;

    localparam int DW = 8;
    localparam int NW = 10;
    localparam int NB = 10;
    localparam int NT = NW + NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n, s_valid, s_valid2, s_last, comp_ready;
    logic [DW-1:0]  s_data;
    logic           s_ready, s_ready2;
    logic [NW*DW-1:0] w_o, w2_o;
    logic [NB*DW-1:0] b_o, b2_o;
    logic           core_reset_n, core_reset_n2, start_comp, start_comp2;
    logic           busy, busy2, done, done2, err_len, err_len2, err_timeout, err_timeout2;
    logic [15:0]    job_count, job_count2;

    sys_array_loader u_dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .input_data_w(w_o), .input_data_b(b_o),
        .core_reset_n(core_reset_n), .start_comp(start_comp), .comp_ready(comp_ready),
        .busy(busy), .done(done), .err_len(err_len), .err_timeout(err_timeout),
        .job_count(job_count)
    );

    sys_array_loader #(.TIMEOUT_CYCLES(16)) u_wd (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid2), .s_ready(s_ready2),
        .s_data(s_data), .s_last(s_last), .input_data_w(w2_o), .input_data_b(b2_o),
        .core_reset_n(core_reset_n2), .start_comp(start_comp2), .comp_ready(1'b0),
        .busy(busy2), .done(done2), .err_len(err_len2), .err_timeout(err_timeout2),
        .job_count(job_count2)
    );

    int          nvec = 0;
    int          nmis = 0;
    logic [DW-1:0] mem [NT];
    int          midx = 0;
    logic        exp_err = 1'b0;
    logic [15:0] exp_jobs = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected packed matrix: elements of the stream concatenated in arrival order, first one on top.
    function automatic logic [79:0] pack(input int base);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[71:0], mem[base + i]};
        return r;
    endfunction

    task automatic set_valid(input bit wd, input logic v);
        if (wd) s_valid2 = v;
        else    s_valid  = v;
    endtask

    task automatic send(input int n, input int lastpos, input bit gaps, input bit wd,
                        input bit seq, input int base);
        logic    acc;
        int      cnt;
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                set_valid(wd, 1'b0);
                repeat ($urandom_range(0, 2)) tick();
            end
            d      = seq ? DW'(base + i) : DW'($urandom);
            s_data = d;
            s_last = (i == lastpos);
            set_valid(wd, 1'b1);
            cnt = 0;
            do begin
                acc = wd ? s_ready2 : s_ready;
                tick();
                cnt++;
            end while (!acc && cnt < 200);
            chk("accept_bound", {127'd0, acc}, 128'd1);
            if (acc && !wd) begin
                if (midx == 0) exp_err = 1'b0;
                mem[midx] = d;
                if (midx == NT - 1) begin
                    if (!(i == lastpos)) exp_err = 1'b1;
                    midx = 0;
                end else if (i == lastpos) begin
                    exp_err = 1'b1;
                    midx = 0;
                end else begin
                    midx++;
                end
            end
        end
        set_valid(wd, 1'b0);
        s_last = 1'b0;
    endtask

    // Called at the sample point right after the final accept edge.
    task automatic complete(input int delay, input bit keep, input bit offer);
        int cnt;
        chk("rst_pulse_low", {127'd0, core_reset_n}, 128'd0);
        chk("no_start_early", {127'd0, start_comp}, 128'd0);
        chk("ready_low_prst", {127'd0, s_ready}, 128'd0);
        chk("busy_job", {127'd0, busy}, 128'd1);
        chk("err_len_job", {127'd0, err_len}, {127'd0, exp_err});
        tick();
        chk("start_pulse", {127'd0, start_comp}, 128'd1);
        chk("rst_pulse_end", {127'd0, core_reset_n}, 128'd1);
        chk("ready_low_start", {127'd0, s_ready}, 128'd0);
        tick();
        chk("start_one_cycle", {127'd0, start_comp}, 128'd0);
        chk("mat_w", {48'd0, w_o}, {48'd0, pack(0)});
        chk("mat_b", {48'd0, b_o}, {48'd0, pack(NW)});
        if (offer) begin
            s_data  = 8'hEE;
            s_valid = 1'b1;
        end
        for (int i = 0; i < delay; i++) begin
            chk("ready_low_wait", {127'd0, s_ready}, 128'd0);
            chk("no_done_wait", {127'd0, done}, 128'd0);
            tick();
        end
        s_valid = 1'b0;
        chk("frozen_w", {48'd0, w_o}, {48'd0, pack(0)});
        chk("frozen_b", {48'd0, b_o}, {48'd0, pack(NW)});
        comp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) cnt++;
        end
        exp_jobs = exp_jobs + 16'd1;
        chk("done_once", 128'(cnt), 128'd1);
        chk("job_count", {112'd0, job_count}, {112'd0, exp_jobs});
        chk("busy_after", {127'd0, busy}, 128'd0);
        chk("ready_after", {127'd0, s_ready}, 128'd1);
        if (!keep) comp_ready = 1'b0;
    endtask

    initial begin
        int  k;
        logic saw_done;
        reset_n = 1'b0; s_valid = 1'b0; s_valid2 = 1'b0; s_last = 1'b0;
        comp_ready = 1'b0; s_data = '0;
        for (int i = 0; i < NT; i++) mem[i] = '0;
        tick(); tick();
        chk("rst_ready", {127'd0, s_ready}, 128'd0);
        chk("rst_core_rst", {127'd0, core_reset_n}, 128'd1);
        chk("rst_start", {127'd0, start_comp}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_errs", {126'd0, err_len, err_timeout}, 128'd0);
        chk("rst_jobs", {112'd0, job_count}, 128'd0);
        chk("rst_w", {48'd0, w_o}, 128'd0);
        reset_n = 1'b1;
        tick();
        chk("load_ready", {127'd0, s_ready}, 128'd1);

        // Nominal load: 1..20, comp_ready 30 cycles into the wait.
        send(NT, NT - 1, 1'b0, 1'b0, 1'b1, 1);
        chk("w00_is_1", {120'd0, w_o[79:72]}, 128'd1);
        chk("w14_is_10", {120'd0, w_o[7:0]}, 128'd10);
        chk("b00_is_11", {120'd0, b_o[79:72]}, 128'd11);
        chk("b41_is_20", {120'd0, b_o[7:0]}, 128'd20);
        complete(30, 1'b0, 1'b0);

        // Backpressure with same data, plus an element offered during the wait.
        send(NT, NT - 1, 1'b1, 1'b0, 1'b1, 1);
        complete(8, 1'b0, 1'b1);

        // Early s_last on element 7 aborts the job.
        send(7, 6, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_err_len", {127'd0, err_len}, {127'd0, exp_err});
            chk("abort_no_rst", {127'd0, core_reset_n}, 128'd1);
            chk("abort_no_start", {127'd0, start_comp}, 128'd0);
            chk("abort_busy", {127'd0, busy}, 128'd0);
            tick();
        end
        chk("abort_partial_w", {48'd0, w_o}, {48'd0, pack(0)});
        send(NT, NT - 1, 1'b1, 1'b0, 1'b0, 0);
        complete(3, 1'b0, 1'b0);

        // Missing s_last: job still runs, length error flagged.
        send(NT, -1, 1'b0, 1'b0, 1'b0, 0);
        complete(5, 1'b0, 1'b0);

        // Stale ready held across two back-to-back jobs.
        comp_ready = 1'b1;
        send(NT, NT - 1, 1'b0, 1'b0, 1'b0, 0);
        complete(0, 1'b1, 1'b0);
        send(NT, NT - 1, 1'b1, 1'b0, 1'b0, 0);
        complete(0, 1'b0, 1'b0);

        // Watchdog on the short-timeout instance.
        send(NT, NT - 1, 1'b0, 1'b1, 1'b0, 0);
        tick();
        chk("wd_start", {127'd0, start_comp2}, 128'd1);
        k = 0;
        saw_done = 1'b0;
        while (!err_timeout2 && k < 40) begin
            tick();
            k++;
            if (done2) saw_done = 1'b1;
        end
        chk("wd_latency", 128'(k), 128'd16);
        chk("wd_err", {127'd0, err_timeout2}, 128'd1);
        chk("wd_no_done", {127'd0, saw_done}, 128'd0);
        chk("wd_jobs", {112'd0, job_count2}, 128'd0);
        chk("wd_ready", {127'd0, s_ready2}, 128'd1);
        chk("wd_busy", {127'd0, busy2}, 128'd0);

        // Reset asserted while waiting on a missing-s_last job.
        send(NT, -1, 1'b0, 1'b0, 1'b0, 0);
        tick(); tick();
        chk("pre_rst_err", {127'd0, err_len}, 128'd1);
        chk("pre_rst_busy", {127'd0, busy}, 128'd1);
        reset_n = 1'b0;
        tick();
        for (int i = 0; i < NT; i++) mem[i] = '0;
        exp_jobs = '0;
        chk("mid_rst_ready", {127'd0, s_ready}, 128'd0);
        chk("mid_rst_core", {127'd0, core_reset_n}, 128'd1);
        chk("mid_rst_ctl", {124'd0, start_comp, busy, done, err_len}, 128'd0);
        chk("mid_rst_tmo", {127'd0, err_timeout}, 128'd0);
        chk("mid_rst_jobs", {112'd0, job_count}, {112'd0, exp_jobs});
        chk("mid_rst_w", {48'd0, w_o}, {48'd0, pack(0)});
        chk("mid_rst_b", {48'd0, b_o}, {48'd0, pack(NW)});
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", {127'd0, s_ready}, 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
